// File: rtl/reg_serializer.sv
// reg_serializer: parallel-to-serial readout for the 8-bit register path.
// Frame: start bit (0), 8 data bits LSB first, optional even parity, stop bit (1).
// Optional feature: define REG_SERIALIZER_PARITY_EN to insert the parity bit.
// tx, busy and done are registered; in_ready is decoded from state and rst.
module reg_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef REG_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [7:0] cyc_cnt;
  logic [2:0] bit_cnt;
`ifdef REG_SERIALIZER_PARITY_EN
  logic       par;
`endif

  // Accept only from IDLE and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;

  // Frame sequencer; tx is loaded with the level of the bit about to start,
  // and done is raised on the edge that enters the final stop-bit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (in_valid && in_ready) begin
            shreg   <= in_data;
`ifdef REG_SERIALIZER_PARITY_EN
            par     <= ^in_data;
`endif
            cyc_cnt <= '0;
            bit_cnt <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (cyc_cnt == LAST) begin
            cyc_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end

        DATA: begin
          if (cyc_cnt == LAST) begin
            cyc_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
              tx      <= par;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              done    <= (LAST == 8'd0);
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              // shreg[1] becomes shreg[0] after this shift
              tx      <= shreg[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end

`ifdef REG_SERIALIZER_PARITY_EN
        PARITY: begin
          if (cyc_cnt == LAST) begin
            cyc_cnt <= '0;
            tx      <= 1'b1;
            done    <= (LAST == 8'd0);
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
`endif

        STOP: begin
          tx <= 1'b1;
          if (cyc_cnt == LAST) begin
            cyc_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
            done    <= (cyc_cnt + 8'd1 == LAST);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_serializer.sv
// tb_reg_serializer: directed scoreboard bench for reg_serializer.
// Three instances (C=4, C=2, C=1) share clk and rst; each has a queue of
// expected per-cycle {tx, busy, done, in_ready} values pushed when stimulus
// is driven and popped one per cycle, sampled 1 time unit after the edge.
module tb_reg_serializer;

`ifdef REG_SERIALIZER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       v4, v2, v1;
  logic [7:0] d4, d2, d1;
  logic       r4, r2, r1;
  logic       t4, t2, t1;
  logic       b4, b2, b1;
  logic       o4, o2, o1;

  int ncmp  = 0;
  int nfail = 0;

  logic [3:0] q4[$];
  logic [3:0] q2[$];
  logic [3:0] q1[$];

  localparam logic [3:0] RST_E  = 4'b1000;
  localparam logic [3:0] IDLE_E = 4'b1001;

  always #5 clk = ~clk;

  reg_serializer #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4),
    .in_ready(r4), .tx(t4), .busy(b4), .done(o4)
  );
  reg_serializer #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2),
    .in_ready(r2), .tx(t2), .busy(b2), .done(o2)
  );
  reg_serializer #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
    .in_ready(r1), .tx(t1), .busy(b1), .done(o1)
  );

  task automatic push(input int dut, input logic [3:0] e);
    case (dut)
      0: q4.push_back(e);
      1: q2.push_back(e);
      default: q1.push_back(e);
    endcase
  endtask

  // Expected frame cycles 1..n for byte b at c clocks per bit.
  task automatic push_frame(input int dut, input logic [7:0] b,
                            input int c, input int n);
    logic [10:0] fr;
    int idx;
    fr = 11'h7FF;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef REG_SERIALIZER_PARITY_EN
    fr[9] = ^b;
    fr[10] = 1'b1;
`else
    fr[9] = 1'b1;
`endif
    for (int k = 1; k <= n; k++) begin
      idx = (k - 1) / c;
      push(dut, {fr[idx], 1'b1, (k == NB * c), 1'b0});
    end
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed {tx,busy,done,rdy}=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    if (q4.size() > 0) cmp("c4", {t4, b4, o4, r4}, q4.pop_front());
    if (q2.size() > 0) cmp("c2", {t2, b2, o2, r2}, q2.pop_front());
    if (q1.size() > 0) cmp("c1", {t1, b1, o1, r1}, q1.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v4 = 1'b1; v2 = 1'b1; v1 = 1'b1;
    d4 = 8'hA5; d2 = 8'hA5; d1 = 8'hA5;

    // reset held 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      push(0, RST_E); push(1, RST_E); push(2, RST_E);
      tick();
    end
    rst = 1'b0;
    v4 = 1'b0; v2 = 1'b0; v1 = 1'b0;
    push(0, IDLE_E); push(1, IDLE_E); push(2, IDLE_E);
    #1;
    check_all();

    // C=4, 0xA5
    d4 = 8'hA5; v4 = 1'b1;
    push_frame(0, 8'hA5, 4, NB * 4);
    tick();
    v4 = 1'b0;
    repeat (NB * 4 - 1) tick();
    push(0, IDLE_E);
    tick();

    // C=4, 0x3C with in_data changed to 0x00 while busy, in_valid held
    d4 = 8'h3C; v4 = 1'b1;
    push_frame(0, 8'h3C, 4, NB * 4);
    tick();
    d4 = 8'h00;
    repeat (NB * 4 - 1) tick();
    v4 = 1'b0;
    push(0, IDLE_E);
    tick();

    // C=4, 0x07 (parity bit 1 when enabled)
    d4 = 8'h07; v4 = 1'b1;
    push_frame(0, 8'h07, 4, NB * 4);
    tick();
    v4 = 1'b0;
    repeat (NB * 4 - 1) tick();
    push(0, IDLE_E);
    tick();

    // C=2 back-to-back 0x01 then 0xFF with in_valid held
    d2 = 8'h01; v2 = 1'b1;
    push_frame(1, 8'h01, 2, NB * 2);
    push(1, IDLE_E);
    push_frame(1, 8'hFF, 2, NB * 2);
    tick();
    d2 = 8'hFF;
    repeat (NB * 2) tick();
    tick();
    v2 = 1'b0;
    repeat (NB * 2 - 1) tick();
    push(1, IDLE_E);
    tick();

    // C=1 boundary, 0x5A
    d1 = 8'h5A; v1 = 1'b1;
    push_frame(2, 8'h5A, 1, NB);
    tick();
    v1 = 1'b0;
    repeat (NB - 1) tick();
    push(2, IDLE_E);
    tick();

    // C=4 reset pulsed in cycle 15, then immediate new accept
    d4 = 8'hC3; v4 = 1'b1;
    push_frame(0, 8'hC3, 4, 15);
    tick();
    v4 = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    push(0, RST_E);
    tick();
    rst = 1'b0;
    d4 = 8'h96; v4 = 1'b1;
    push_frame(0, 8'h96, 4, NB * 4);
    tick();
    v4 = 1'b0;
    repeat (NB * 4 - 1) tick();
    push(0, IDLE_E);
    tick();

    // every expectation consumed
    ncmp++;
    assert (q4.size() + q2.size() + q1.size() == 0) else begin
      nfail++;
      $error("FAIL drain: observed %0d left expected 0", q4.size() + q2.size() + q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
